load_commutator: RTL and testbench

LOAD_COMMUTATOR -- requirements
Module: load_commutator

---
 rtl/load_commutator.sv | 175 +++++++++++++++++
 tb/tb_load_commutator.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_commutator.sv
// load_commutator: make-before-break commutation between bidirectional loads.
// Each load k has a P and an N switch. Sout is the registered gate vector.
// Define FAULT_OPEN_EN to add the 'fault' port and the latched FAULT state,
// which forces every switch open until the next reset.
module load_commutator #(
  parameter int NLOADS = 3,
  parameter int DWELL  = 2,
  localparam int SEL_W = $clog2(NLOADS + 1),
  localparam int SW_W  = 2 * NLOADS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] DesiredLoad,
  input  logic             CurrentSign,
`ifdef FAULT_OPEN_EN
  input  logic             fault,
`endif
  output logic [SW_W-1:0]  Sout,
  output logic [SEL_W-1:0] cur_load,
  output logic             busy,
  output logic             done,
  output logic             sel_err
);

  typedef enum logic [2:0] {
    IDLE,
    ON,
    STEP1,
    STEP2,
    STEP3
`ifdef FAULT_OPEN_EN
    , FAULT
`endif
  } state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_t           state, state_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic [SEL_W-1:0] tgt, tgt_nxt;
  logic             sgn, sgn_nxt;
  logic [SW_W-1:0]  sout_nxt;
  logic [SEL_W-1:0] cur_nxt;
  logic             busy_nxt, done_nxt, err_nxt;
  logic             req_valid, req_oor, step_last;

  // One-hot mask selecting the N switch of load k (P sits one bit above)
  function automatic logic [SW_W-1:0] nmask(input logic [SEL_W-1:0] k);
    logic [SW_W-1:0] m;
    m    = '0;
    m[0] = 1'b1;
    return m << (2 * (NLOADS - int'(k)));
  endfunction

  function automatic logic [SW_W-1:0] pmask(input logic [SEL_W-1:0] k);
    return nmask(k) << 1;
  endfunction

  assign req_oor   = int'(DesiredLoad) > NLOADS;
  assign req_valid = (DesiredLoad != '0) && !req_oor;
  assign step_last = (cnt == DWELL_LAST);

  // Next-state logic: each step edits only the switches it owns, so the
  // vector never opens a conducting path before the new one is closed
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tgt_nxt   = tgt;
    sgn_nxt   = sgn;
    sout_nxt  = Sout;
    cur_nxt   = cur_load;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = req_oor;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt = ON;
          sout_nxt  = pmask(DesiredLoad) | nmask(DesiredLoad);
          cur_nxt   = DesiredLoad;
          done_nxt  = 1'b1;
        end
      end
      ON: begin
        if (req_valid && (DesiredLoad != cur_load)) begin
          state_nxt = STEP1;
          cnt_nxt   = '0;
          tgt_nxt   = DesiredLoad;
          sgn_nxt   = CurrentSign;
          busy_nxt  = 1'b1;
          sout_nxt  = Sout & ~(CurrentSign ? nmask(cur_load) : pmask(cur_load));
        end
      end
      STEP1: begin
        busy_nxt = 1'b1;
        if (step_last) begin
          state_nxt = STEP2;
          cnt_nxt   = '0;
          sout_nxt  = Sout | (sgn ? pmask(tgt) : nmask(tgt));
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      STEP2: begin
        busy_nxt = 1'b1;
        if (step_last) begin
          state_nxt = STEP3;
          cnt_nxt   = '0;
          sout_nxt  = Sout & ~(sgn ? pmask(cur_load) : nmask(cur_load));
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      STEP3: begin
        if (step_last) begin
          state_nxt = ON;
          cnt_nxt   = '0;
          sout_nxt  = Sout | (sgn ? nmask(tgt) : pmask(tgt));
          cur_nxt   = tgt;
          done_nxt  = 1'b1;
        end else begin
          busy_nxt = 1'b1;
          cnt_nxt  = cnt + 8'd1;
        end
      end
`ifdef FAULT_OPEN_EN
      FAULT: begin
        sout_nxt = '0;
        cur_nxt  = '0;
      end
`endif
      default: begin
        state_nxt = IDLE;
        sout_nxt  = '0;
        cur_nxt   = '0;
      end
    endcase
`ifdef FAULT_OPEN_EN
    if (fault) begin
      state_nxt = FAULT;
      cnt_nxt   = '0;
      sout_nxt  = '0;
      cur_nxt   = '0;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
    end
`endif
  end

  // State and registered outputs; reset wins over every input
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      tgt      <= '0;
      sgn      <= 1'b0;
      Sout     <= '0;
      cur_load <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sel_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      tgt      <= tgt_nxt;
      sgn      <= sgn_nxt;
      Sout     <= sout_nxt;
      cur_load <= cur_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      sel_err  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_load_commutator.sv
// tb_load_commutator: table vectors, hand sequences and randomized traffic
// for load_commutator (3 loads / dwell 2, plus a 4 loads / dwell 3 copy).
// Optional fault checks are compiled when FAULT_OPEN_EN is defined.
module tb_load_commutator;

  localparam int NL  = 3;
  localparam int DW  = 2;
  localparam int NL4 = 4;
  localparam int DW4 = 3;

  logic clk = 1'b0;

  // Free-running clock shared by both instances
  always #5 clk = ~clk;

  logic       rst, sign;
  logic [1:0] dl;
  logic [5:0] sout;
  logic [1:0] cur;
  logic       busy, done, serr;

  logic       rst4, sign4;
  logic [2:0] dl4;
  logic [7:0] sout4;
  logic [2:0] cur4;
  logic       busy4, done4, serr4;

  logic fault_drv  = 1'b0;
  logic fault4_drv = 1'b0;

  load_commutator #(.NLOADS(NL), .DWELL(DW)) dut (
    .clk(clk), .rst(rst), .DesiredLoad(dl), .CurrentSign(sign),
`ifdef FAULT_OPEN_EN
    .fault(fault_drv),
`endif
    .Sout(sout), .cur_load(cur), .busy(busy), .done(done), .sel_err(serr)
  );

  load_commutator #(.NLOADS(NL4), .DWELL(DW4)) dut4 (
    .clk(clk), .rst(rst4), .DesiredLoad(dl4), .CurrentSign(sign4),
`ifdef FAULT_OPEN_EN
    .fault(fault4_drv),
`endif
    .Sout(sout4), .cur_load(cur4), .busy(busy4), .done(done4), .sel_err(serr4)
  );

  int nChecks = 0;
  int nPass   = 0;
  int busyCount;

  // Reference model: which switches are closed, and how far into a sequence
  bit m_p [1:NL];
  bit m_n [1:NL];
  int m_conn, m_tgt, m_pos;
  bit m_active, m_sgn, m_done, m_err, m_fault;

  typedef struct {
    bit         rst;
    logic [1:0] dl;
    bit         sg;
    logic [5:0] sout;
    bit         busy;
    bit         done;
    logic [1:0] cur;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input bit r, input logic [1:0] d, input bit sg,
                        input logic [5:0] s, input bit b, input bit dn, input logic [1:0] c);
    vec_t v;
    v.rst = r; v.dl = d; v.sg = sg; v.sout = s; v.busy = b; v.done = dn; v.cur = c;
    vecs.push_back(v);
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // One clock edge of the behaviour: timeline position within a sequence
  // decides which switch moves (0, DW, 2*DW, 3*DW)
  task automatic modelEdge(input bit r, input int d, input bit sg, input bit f);
    m_done = 1'b0;
    if (r) begin
      for (int k = 1; k <= NL; k++) begin m_p[k] = 1'b0; m_n[k] = 1'b0; end
      m_conn = 0; m_active = 1'b0; m_err = 1'b0; m_fault = 1'b0;
      return;
    end
    m_err = (d > NL);
    if (f) begin
      for (int k = 1; k <= NL; k++) begin m_p[k] = 1'b0; m_n[k] = 1'b0; end
      m_conn = 0; m_active = 1'b0; m_fault = 1'b1;
      return;
    end
    if (m_fault) return;
    if (m_conn == 0) begin
      if (d >= 1 && d <= NL) begin
        m_p[d] = 1'b1; m_n[d] = 1'b1; m_conn = d; m_done = 1'b1;
      end
    end else if (m_active) begin
      m_pos++;
      if (m_pos == DW) begin
        if (m_sgn) m_p[m_tgt] = 1'b1; else m_n[m_tgt] = 1'b1;
      end else if (m_pos == 2 * DW) begin
        if (m_sgn) m_p[m_conn] = 1'b0; else m_n[m_conn] = 1'b0;
      end else if (m_pos == 3 * DW) begin
        if (m_sgn) m_n[m_tgt] = 1'b1; else m_p[m_tgt] = 1'b1;
        m_conn = m_tgt; m_active = 1'b0; m_done = 1'b1;
      end
    end else if (d >= 1 && d <= NL && d != m_conn) begin
      m_active = 1'b1; m_pos = 0; m_tgt = d; m_sgn = sg;
      if (sg) m_n[m_conn] = 1'b0; else m_p[m_conn] = 1'b0;
    end
  endtask

  function automatic logic [5:0] modelSout();
    logic [5:0] s;
    s = '0;
    for (int k = 1; k <= NL; k++) begin
      s = s | (6'(m_p[k]) << (2 * (NL - k) + 1));
      s = s | (6'(m_n[k]) << (2 * (NL - k)));
    end
    return s;
  endfunction

  task automatic applyStimulus(input bit r, input logic [1:0] d, input bit sg);
    rst = r; dl = d; sign = sg;
    @(posedge clk);
    modelEdge(r, int'(d), sg, fault_drv);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, " Sout"}, 32'(sout), 32'(modelSout()));
    checkVal({tag, " busy"}, 32'(busy), 32'(m_active));
    checkVal({tag, " done"}, 32'(done), 32'(m_done));
    checkVal({tag, " sel_err"}, 32'(serr), 32'(m_err));
    if (!m_active) checkVal({tag, " cur_load"}, 32'(cur), 32'(m_conn));
  endtask

  task automatic step4(input bit r, input logic [2:0] d, input bit sg);
    rst4 = r; dl4 = d; sign4 = sg;
    @(posedge clk);
    #1;
  endtask

  task automatic check4(input string tag, input logic [7:0] s, input bit b, input bit dn,
                        input bit e, input logic [2:0] c);
    checkVal({tag, " Sout"}, 32'(sout4), 32'(s));
    checkVal({tag, " busy"}, 32'(busy4), 32'(b));
    checkVal({tag, " done"}, 32'(done4), 32'(dn));
    checkVal({tag, " sel_err"}, 32'(serr4), 32'(e));
    if (!b) checkVal({tag, " cur_load"}, 32'(cur4), 32'(c));
  endtask

  // Main test sequence
  initial begin
    logic [7:0] exp4 [10];
    logic [1:0] rd;
    rst = 1'b1; dl = '0; sign = 1'b0;
    rst4 = 1'b1; dl4 = '0; sign4 = 1'b0;

    // Reset, connect 1, sgn=1 to 2, sgn=1 to 3, sgn=0 back to 1, holds
    addVec(1, 0, 0, 6'b000000, 0, 0, 0);
    addVec(0, 1, 1, 6'b110000, 0, 1, 1);
    addVec(0, 1, 1, 6'b110000, 0, 0, 1);
    addVec(0, 2, 1, 6'b100000, 1, 0, 1);
    addVec(0, 2, 0, 6'b100000, 1, 0, 1);
    addVec(0, 2, 0, 6'b101000, 1, 0, 1);
    addVec(0, 2, 1, 6'b101000, 1, 0, 1);
    addVec(0, 2, 1, 6'b001000, 1, 0, 1);
    addVec(0, 2, 1, 6'b001000, 1, 0, 1);
    addVec(0, 2, 1, 6'b001100, 0, 1, 2);
    addVec(0, 2, 1, 6'b001100, 0, 0, 2);
    addVec(0, 3, 1, 6'b001000, 1, 0, 2);
    addVec(0, 3, 0, 6'b001000, 1, 0, 2);
    addVec(0, 3, 0, 6'b001010, 1, 0, 2);
    addVec(0, 3, 1, 6'b001010, 1, 0, 2);
    addVec(0, 3, 1, 6'b000010, 1, 0, 2);
    addVec(0, 3, 1, 6'b000010, 1, 0, 2);
    addVec(0, 3, 1, 6'b000011, 0, 1, 3);
    addVec(0, 1, 0, 6'b000001, 1, 0, 3);
    addVec(0, 1, 1, 6'b000001, 1, 0, 3);
    addVec(0, 1, 0, 6'b010001, 1, 0, 3);
    addVec(0, 1, 1, 6'b010001, 1, 0, 3);
    addVec(0, 1, 0, 6'b010000, 1, 0, 3);
    addVec(0, 1, 1, 6'b010000, 1, 0, 3);
    addVec(0, 1, 1, 6'b110000, 0, 1, 1);
    addVec(0, 0, 1, 6'b110000, 0, 0, 1);
    addVec(0, 1, 0, 6'b110000, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].dl, vecs[i].sg);
      checkVal($sformatf("vec%0d Sout", i), 32'(sout), 32'(vecs[i].sout));
      checkVal($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].busy));
      checkVal($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].done));
      if (!vecs[i].busy) checkVal($sformatf("vec%0d cur_load", i), 32'(cur), 32'(vecs[i].cur));
    end

    // Request retargeted mid-STEP2: lands on 2, one ON cycle, then goes to 3
    busyCount = 0;
    for (int i = 0; i < 14; i++) begin
      applyStimulus(0, (i < 3) ? 2'd2 : 2'd3, 1'($urandom_range(1)));
      checkOutput($sformatf("retarget%0d", i));
      if (i <= 6) busyCount += int'(busy);
      if (i == 6) checkVal("retarget landed", 32'(cur), 32'd2);
      if (i == 7) checkVal("retarget restart", 32'(busy), 32'd1);
      if (i == 13) checkVal("retarget final", 32'(cur), 32'd3);
    end
    checkVal("busy length", 32'(busyCount), 32'(3 * DW));

    // Randomized traffic against the model, with occasional resets
    rd = 2'd3;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) rd = 2'($urandom_range(3));
      applyStimulus($urandom_range(49) == 0, rd, 1'($urandom_range(1)));
      checkOutput("random");
    end

`ifdef FAULT_OPEN_EN
    // Fault during STEP3 opens everything and latches until reset
    applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 2, 1);
    fault_drv = 1'b1;
    applyStimulus(0, 2, 1);
    checkVal("fault open", 32'(sout), 32'd0);
    checkOutput("fault");
    fault_drv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 3, 1);
      checkVal("fault held", 32'(sout), 32'd0);
      checkOutput("fault held");
    end
    applyStimulus(1, 3, 1);
    applyStimulus(0, 3, 1);
    checkVal("fault recover", 32'(sout), 32'b000011);
    checkOutput("fault recover");
`endif

    // Four loads, dwell 3: range error, reset mid-STEP1, step timing
    step4(1, 0, 0);  check4("n4 reset", 8'h00, 0, 0, 0, 0);
    step4(0, 7, 1);  check4("n4 oor idle", 8'h00, 0, 0, 1, 0);
    step4(0, 2, 1);  check4("n4 connect2", 8'h30, 0, 1, 0, 2);
    step4(0, 7, 1);  check4("n4 oor held", 8'h30, 0, 0, 1, 2);
    step4(0, 4, 1);  check4("n4 step1", 8'h20, 1, 0, 0, 2);
    step4(1, 4, 1);  check4("n4 reset mid", 8'h00, 0, 0, 0, 0);
    step4(1, 3, 0);  check4("n4 reset hold", 8'h00, 0, 0, 0, 0);
    step4(0, 1, 0);  check4("n4 connect1", 8'hC0, 0, 1, 0, 1);
    exp4 = '{8'h40, 8'h40, 8'h40, 8'h50, 8'h50, 8'h50, 8'h10, 8'h10, 8'h10, 8'h30};
    for (int i = 0; i < 10; i++) begin
      step4(0, 3'd2, (i == 0) ? 1'b0 : 1'($urandom_range(1)));
      check4($sformatf("n4 seq%0d", i), exp4[i], i < 9, i == 9, 0, 2);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
